// File: rtl/parking_request_dispatcher.sv
// Request queue plus slot resolver ahead of the elevator: one command in flight at a time.
// Optional macro PARK_LEAK_AVOID_EN keeps allocations and retrieval commands away from flooded floors.
module parking_request_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int SUV_BIT    = 11
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 license_plate,
  input  logic                        in_mode,
  input  logic                        out_mode,
  input  logic [223:0]                slot_plates,
  input  logic [6:0]                  leak_floor_mask,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_is_out,
  output logic [15:0]                 cmd_plate,
  output logic [2:0]                  cmd_floor,
  output logic                        cmd_place,
  input  logic                        cmd_done,
  output logic                        reject,
  output logic [1:0]                  reject_code,
  output logic [$clog2(FIFO_DEPTH):0] queue_count,
  output logic                        busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PD  = 2 * FIFO_DEPTH;
  localparam int PAW = AW + 1;

  localparam logic [1:0] LOT_FULL  = 2'd0;
  localparam logic [1:0] NOT_FOUND = 2'd1;
  localparam logic [1:0] BAD_REQ   = 2'd2;
  localparam logic [1:0] OVERFLOW  = 2'd3;

  // Slot index k = (floor-1)*2 + place, so bit k marks a legal slot for that class.
  localparam logic [13:0] SUV_SLOTS   = 14'h3332;
  localparam logic [13:0] SEDAN_SLOTS = 14'h0CC8;

  typedef enum logic [2:0] {IDLE, ALLOC, SEARCH, ISSUE, WAIT_DONE} state_t;

  state_t      state;
  logic [15:0] req_plate;
  logic [3:0]  search_k;

  logic [16:0]   q_mem [FIFO_DEPTH];
  logic [AW-1:0] q_wr, q_rd;
  logic [AW:0]   q_count;
  logic          q_full, push, pop;
  logic          bad_req, good_req, ovf_req, enq_rej;
  logic [1:0]    enq_code;
  logic          head_is_out;
  logic [15:0]   head_plate;

  logic [15:0] slot_arr [14];
  logic [13:0] empty_k, match_k, flood_k, cand;
  logic [7:0]  leak8;
  logic        alloc_found, match;
  logic [3:0]  alloc_k, sel_k;
  logic [2:0]  sel_floor;
  logic        sel_ready;
  logic        fsm_rej;
  logic [1:0]  fsm_code;

  logic [1:0]     p_mem [PD];
  logic [PAW-1:0] p_wr, p_rd;
  logic [PAW:0]   p_count;
  logic           p_empty, p_full, p_push, p_pop;

  assign q_full      = (q_count == (AW+1)'(FIFO_DEPTH));
  assign bad_req     = (in_mode && out_mode) || ((in_mode || out_mode) && (license_plate == 16'h0000));
  assign good_req    = (in_mode ^ out_mode) && (license_plate != 16'h0000);
  assign push        = good_req && !q_full;
  assign ovf_req     = good_req && q_full;
  assign enq_rej     = bad_req || ovf_req;
  assign enq_code    = bad_req ? BAD_REQ : OVERFLOW;
  assign pop         = (state == IDLE) && (q_count != '0);
  assign head_is_out = q_mem[q_rd][16];
  assign head_plate  = q_mem[q_rd][15:0];
  assign queue_count = q_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
    end else begin
      if (push) q_wr <= q_wr + AW'(1);
      if (pop)  q_rd <= q_rd + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (AW+1)'(1);
        2'b01:   q_count <= q_count - (AW+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) q_mem[q_wr] <= {out_mode, license_plate};
  end

  always_comb begin
    for (int f = 0; f < 7; f++) begin
      slot_arr[2*f]   = slot_plates[f*32+16 +: 16];
      slot_arr[2*f+1] = slot_plates[f*32 +: 16];
    end
  end

  always_comb begin
    empty_k = '0;
    match_k = '0;
    for (int k = 0; k < 14; k++) begin
      empty_k[k] = (slot_arr[k] == 16'h0000);
      match_k[k] = (slot_arr[k] == req_plate);
    end
  end

`ifdef PARK_LEAK_AVOID_EN
  always_comb begin
    flood_k = '0;
    for (int k = 0; k < 14; k++) flood_k[k] = leak_floor_mask[k/2];
  end
  assign leak8 = {leak_floor_mask, 1'b0};
`else
  logic leak_unused;
  assign leak_unused = ^leak_floor_mask;
  assign flood_k     = '0;
  assign leak8       = '0;
`endif

  assign cand = (req_plate[SUV_BIT] ? SUV_SLOTS : SEDAN_SLOTS) & empty_k & ~flood_k;

  // Scanning downward leaves the lowest legal free slot as the winner.
  always_comb begin
    alloc_found = 1'b0;
    alloc_k     = '0;
    for (int i = 13; i >= 0; i--) begin
      if (cand[i]) begin
        alloc_found = 1'b1;
        alloc_k     = 4'(i);
      end
    end
  end

  assign match     = match_k[search_k];
  assign sel_k     = (state == SEARCH) ? search_k : alloc_k;
  assign sel_floor = sel_k[3:1] + 3'd1;
  assign sel_ready = !leak8[sel_floor];
  assign fsm_rej   = ((state == ALLOC) && !alloc_found) ||
                     ((state == SEARCH) && !match && (search_k == 4'd13));
  assign fsm_code  = (state == ALLOC) ? LOT_FULL : NOT_FOUND;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_plate  <= '0;
      search_k   <= '0;
      cmd_valid  <= 1'b0;
      cmd_is_out <= 1'b0;
      cmd_plate  <= '0;
      cmd_floor  <= '0;
      cmd_place  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            req_plate <= head_plate;
            search_k  <= '0;
            busy      <= 1'b1;
            state     <= head_is_out ? SEARCH : ALLOC;
          end
        end
        ALLOC: begin
          if (alloc_found) begin
            cmd_floor  <= sel_floor;
            cmd_place  <= sel_k[0];
            cmd_plate  <= req_plate;
            cmd_is_out <= 1'b0;
            cmd_valid  <= sel_ready;
            state      <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEARCH: begin
          if (match) begin
            cmd_floor  <= sel_floor;
            cmd_place  <= sel_k[0];
            cmd_plate  <= req_plate;
            cmd_is_out <= 1'b1;
            cmd_valid  <= sel_ready;
            state      <= ISSUE;
          end else if (search_k == 4'd13) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            search_k <= search_k + 4'd1;
          end
        end
        ISSUE: begin
          // Once offered, the command stays offered even if its floor floods.
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT_DONE;
          end else if (!cmd_valid) begin
            cmd_valid <= !leak8[cmd_floor];
          end
        end
        WAIT_DONE: begin
          if (cmd_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enqueue rejects that collide with an FSM reject wait here so none is dropped.
  assign p_empty = (p_count == '0);
  assign p_full  = (p_count == (PAW+1)'(PD));
  assign p_push  = enq_rej && (fsm_rej || !p_empty) && !p_full;
  assign p_pop   = !fsm_rej && !p_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reject      <= 1'b0;
      reject_code <= '0;
      p_wr        <= '0;
      p_rd        <= '0;
      p_count     <= '0;
    end else begin
      if (fsm_rej) begin
        reject      <= 1'b1;
        reject_code <= fsm_code;
      end else if (!p_empty) begin
        reject      <= 1'b1;
        reject_code <= p_mem[p_rd];
      end else if (enq_rej) begin
        reject      <= 1'b1;
        reject_code <= enq_code;
      end else begin
        reject <= 1'b0;
      end
      if (p_push) p_wr <= p_wr + PAW'(1);
      if (p_pop)  p_rd <= p_rd + PAW'(1);
      case ({p_push, p_pop})
        2'b10:   p_count <= p_count + (PAW+1)'(1);
        2'b01:   p_count <= p_count - (PAW+1)'(1);
        default: p_count <= p_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (p_push) p_mem[p_wr] <= enq_code;
  end

endmodule

// File: tb/tb_parking_request_dispatcher.sv
// Directed self-checking bench for parking_request_dispatcher (default FIFO_DEPTH=4, SUV_BIT=11).
module tb_parking_request_dispatcher;

  logic         clock = 1'b0;
  logic         reset;
  logic [15:0]  license_plate;
  logic         in_mode, out_mode;
  logic [223:0] slot_plates;
  logic [6:0]   leak_floor_mask;
  logic         cmd_valid, cmd_ready, cmd_is_out, cmd_place, cmd_done;
  logic [15:0]  cmd_plate;
  logic [2:0]   cmd_floor;
  logic         reject, busy;
  logic [1:0]   reject_code;
  logic [2:0]   queue_count;

  int checks = 0;
  int errors = 0;
  int cyc;

  parking_request_dispatcher dut (
    .clock(clock), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .slot_plates(slot_plates),
    .leak_floor_mask(leak_floor_mask), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_out(cmd_is_out), .cmd_plate(cmd_plate), .cmd_floor(cmd_floor),
    .cmd_place(cmd_place), .cmd_done(cmd_done), .reject(reject),
    .reject_code(reject_code), .queue_count(queue_count), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input bit in_p, input bit out_p, input logic [15:0] plate);
    in_mode = in_p;
    out_mode = out_p;
    license_plate = plate;
    tick();
    in_mode = 1'b0;
    out_mode = 1'b0;
    license_plate = '0;
  endtask

  task automatic set_slot(input int f, input bit right, input logic [15:0] p);
    slot_plates[(f-1)*32 + (right ? 0 : 16) +: 16] = p;
  endtask

  // Called in cycle 1 of a request; returns the cycle index where cmd_valid was seen.
  task automatic wait_valid(input int max_cycles, output int n);
    n = 1;
    while (cmd_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic complete_cmd();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  task automatic do_reset();
    in_mode = 1'b0;
    out_mode = 1'b0;
    license_plate = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    slot_plates = '0;
    leak_floor_mask = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_mode = 1'b0;
    out_mode = 1'b0;
    license_plate = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    slot_plates = '0;
    leak_floor_mask = '0;
    tick();
    chk("reset_queue_count", 32'(queue_count), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cmd_valid", 32'(cmd_valid), 0);
    chk("reset_reject", 32'(reject), 0);
    chk("reset_reject_code", 32'(reject_code), 0);
    chk("reset_cmd_floor", 32'(cmd_floor), 0);
    chk("reset_cmd_plate", 32'(cmd_plate), 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_park_in_latency();
    $display("[TB] park-in latency");
    send(1'b1, 1'b0, 16'h0801);
    chk("lat_c1_queue_count", 32'(queue_count), 1);
    chk("lat_c1_cmd_valid", 32'(cmd_valid), 0);
    tick();
    chk("lat_c2_busy", 32'(busy), 1);
    chk("lat_c2_queue_count", 32'(queue_count), 0);
    chk("lat_c2_cmd_valid", 32'(cmd_valid), 0);
    tick();
    chk("lat_c3_cmd_valid", 32'(cmd_valid), 1);
    chk("lat_c3_cmd_floor", 32'(cmd_floor), 1);
    chk("lat_c3_cmd_place", 32'(cmd_place), 1);
    chk("lat_c3_cmd_is_out", 32'(cmd_is_out), 0);
    chk("lat_c3_cmd_plate", 32'(cmd_plate), 32'h0801);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("lat_after_hs_valid", 32'(cmd_valid), 0);
    chk("lat_after_hs_busy", 32'(busy), 1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("lat_after_done_busy", 32'(busy), 0);
  endtask

  task automatic test_sedan_hold();
    $display("[TB] sedan park-in and hold without done");
    cmd_ready = 1'b1;
    send(1'b1, 1'b0, 16'h1234);
    wait_valid(20, cyc);
    chk("sedan_latency", 32'(cyc), 3);
    chk("sedan_cmd_valid", 32'(cmd_valid), 1);
    chk("sedan_cmd_floor", 32'(cmd_floor), 2);
    chk("sedan_cmd_place", 32'(cmd_place), 1);
    tick();
    send(1'b1, 1'b0, 16'h0900);
    repeat (5) tick();
    chk("hold_busy", 32'(busy), 1);
    chk("hold_cmd_valid", 32'(cmd_valid), 0);
    chk("hold_queue_count", 32'(queue_count), 1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    wait_valid(10, cyc);
    chk("second_cmd_valid", 32'(cmd_valid), 1);
    chk("second_cmd_floor", 32'(cmd_floor), 1);
    chk("second_cmd_place", 32'(cmd_place), 1);
    chk("second_cmd_plate", 32'(cmd_plate), 32'h0900);
    complete_cmd();
  endtask

  task automatic test_park_out();
    $display("[TB] park-out search");
    set_slot(5, 1'b0, 16'h0A55);
    send(1'b0, 1'b1, 16'h0A55);
    wait_valid(30, cyc);
    chk("out_latency", 32'(cyc), 11);
    chk("out_cmd_valid", 32'(cmd_valid), 1);
    chk("out_cmd_is_out", 32'(cmd_is_out), 1);
    chk("out_cmd_floor", 32'(cmd_floor), 5);
    chk("out_cmd_place", 32'(cmd_place), 0);
    chk("out_cmd_plate", 32'(cmd_plate), 32'h0A55);
    complete_cmd();
    send(1'b0, 1'b1, 16'h7777);
    cyc = 1;
    while (reject !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("notfound_reject", 32'(reject), 1);
    chk("notfound_cycle", 32'(cyc), 16);
    chk("notfound_code", 32'(reject_code), 1);
    chk("notfound_busy", 32'(busy), 0);
    tick();
    chk("notfound_pulse_width", 32'(reject), 0);
    slot_plates = '0;
  endtask

  task automatic test_lot_full_coincide();
    $display("[TB] SUV lot full with coincident bad request");
    set_slot(1, 1'b1, 16'h0811);
    set_slot(3, 1'b0, 16'h0812);
    set_slot(3, 1'b1, 16'h0813);
    set_slot(5, 1'b0, 16'h0814);
    set_slot(5, 1'b1, 16'h0815);
    set_slot(7, 1'b0, 16'h0816);
    set_slot(7, 1'b1, 16'h0817);
    send(1'b1, 1'b0, 16'h0801);
    tick();
    send(1'b1, 1'b1, 16'h0100);
    chk("full_reject", 32'(reject), 1);
    chk("full_code", 32'(reject_code), 0);
    chk("full_busy", 32'(busy), 0);
    tick();
    chk("delayed_reject", 32'(reject), 1);
    chk("delayed_code", 32'(reject_code), 2);
    tick();
    chk("delayed_reject_ends", 32'(reject), 0);
    chk("full_queue_count", 32'(queue_count), 0);
    slot_plates = '0;
  endtask

  task automatic test_overflow();
    $display("[TB] queue overflow and bad requests");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_mode = 1'b1;
      license_plate = 16'(16'h0010 + i);
      tick();
    end
    in_mode = 1'b0;
    license_plate = '0;
    chk("ovf_queue_full", 32'(queue_count), 4);
    chk("ovf_no_reject_yet", 32'(reject), 0);
    chk("ovf_stalled_valid", 32'(cmd_valid), 1);
    send(1'b1, 1'b0, 16'h0020);
    chk("ovf_reject", 32'(reject), 1);
    chk("ovf_code", 32'(reject_code), 3);
    chk("ovf_queue_kept", 32'(queue_count), 4);
    send(1'b1, 1'b1, 16'h0021);
    chk("both_reject", 32'(reject), 1);
    chk("both_code", 32'(reject_code), 2);
    send(1'b1, 1'b0, 16'h0000);
    chk("zero_plate_reject", 32'(reject), 1);
    chk("zero_plate_code", 32'(reject_code), 2);
    do_reset();
  endtask

  task automatic test_reset_mid_command();
    $display("[TB] reset while waiting for done");
    cmd_ready = 1'b1;
    in_mode = 1'b1;
    license_plate = 16'h0801;
    tick();
    license_plate = 16'h0011;
    tick();
    license_plate = 16'h0012;
    tick();
    in_mode = 1'b0;
    license_plate = '0;
    chk("mid_c3_valid", 32'(cmd_valid), 1);
    tick();
    cmd_ready = 1'b0;
    chk("mid_wait_busy", 32'(busy), 1);
    chk("mid_wait_valid", 32'(cmd_valid), 0);
    chk("mid_wait_queue", 32'(queue_count), 2);
    reset = 1'b1;
    #1;
    chk("mid_reset_queue", 32'(queue_count), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_valid", 32'(cmd_valid), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("late_done_busy", 32'(busy), 0);
    tick();
    chk("late_done_valid", 32'(cmd_valid), 0);
    chk("late_done_queue", 32'(queue_count), 0);
  endtask

`ifdef PARK_LEAK_AVOID_EN
  task automatic test_leak_avoid();
    $display("[TB] leak avoidance");
    do_reset();
    leak_floor_mask = 7'b0000001;
    send(1'b1, 1'b0, 16'h0801);
    wait_valid(20, cyc);
    chk("leak_cmd_valid", 32'(cmd_valid), 1);
    chk("leak_cmd_floor", 32'(cmd_floor), 3);
    chk("leak_cmd_place", 32'(cmd_place), 0);
    complete_cmd();
    leak_floor_mask = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_park_in_latency();
    test_sedan_hold();
    test_park_out();
    test_lot_full_coincide();
    test_overflow();
    test_reset_mid_command();
`ifdef PARK_LEAK_AVOID_EN
    test_leak_avoid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
